// File: rtl/fsm4_pkg.sv
// Shared types for the AES round-sequencing controllers.
// The encryption state_e and the decrypt-side dec_state_e both live here.
package fsm4_pkg;

  typedef enum logic [2:0] {
    ENC_IDLE,
    ENC_INITIAL_ROUND,
    ENC_MID_ROUND,
    ENC_LAST_ROUND,
    ENC_DONE
  } state_e;

  typedef enum logic [2:0] {
    IDLE,
    INITIAL_ROUND,
    MID_ROUND,
    LAST_ROUND,
    DONE
  } dec_state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    INV_SR_SB = 2'd1,
    ARK       = 2'd2,
    INV_MC    = 2'd3
  } round_step_e;

  localparam logic [1:0] PHASE_0 = 2'd0;
  localparam logic [1:0] PHASE_1 = 2'd1;
  localparam logic [1:0] PHASE_2 = 2'd2;

endpackage

// File: rtl/decryption_fsm.sv
// AES inverse-cipher control FSM: initial ARK, NUM_ROUNDS-1 inverse middle
// rounds, inverse last round; round keys fetched in reverse order over req/valid.
//
// state         | meaning
// IDLE          | waiting for start
// INITIAL_ROUND | ARK with key NUM_ROUNDS on ciphertext input
// MID_ROUND     | phase 0 InvSR/SB, phase 1 ARK, phase 2 InvMC
// LAST_ROUND    | phase 0 InvSR/SB, phase 1 ARK with key 0
// DONE          | one-cycle done pulse, plaintext in state register
module decryption_fsm
  import fsm4_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 key_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 mux_sel,
  output logic                 load_state,
  output logic [1:0]           round_step,
  output logic                 req_key,
  output logic [KEY_IDX_W-1:0] key_idx
);

  localparam logic [KEY_IDX_W-1:0] RC_INIT = KEY_IDX_W'(NUM_ROUNDS);
  localparam logic [KEY_IDX_W-1:0] RC_ONE  = KEY_IDX_W'(1);

  dec_state_e           state, state_n;
  logic [KEY_IDX_W-1:0] round_count, round_count_n;
  logic [1:0]           phase, phase_n;
  round_step_e          step;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      round_count <= RC_INIT;
      phase       <= PHASE_0;
    end else begin
      state       <= state_n;
      round_count <= round_count_n;
      phase       <= phase_n;
    end
  end

  always_comb begin
    state_n       = state;
    round_count_n = round_count;
    phase_n       = phase;
    busy          = 1'b0;
    done          = 1'b0;
    mux_sel       = 1'b0;
    load_state    = 1'b0;
    step          = NONE;
    req_key       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n       = INITIAL_ROUND;
          round_count_n = RC_INIT;
        end
      end

      INITIAL_ROUND: begin
        busy       = 1'b1;
        step       = ARK;
        req_key    = 1'b1;
        load_state = key_valid;
        if (key_valid) begin
          state_n       = MID_ROUND;
          phase_n       = PHASE_0;
          round_count_n = RC_INIT - RC_ONE;
        end
      end

      MID_ROUND: begin
        busy    = 1'b1;
        mux_sel = 1'b1;
        case (phase)
          PHASE_0: begin
            step       = INV_SR_SB;
            load_state = 1'b1;
            phase_n    = PHASE_1;
          end
          PHASE_1: begin
            step       = ARK;
            req_key    = 1'b1;
            load_state = key_valid;
            if (key_valid) phase_n = PHASE_2;
          end
          PHASE_2: begin
            step       = INV_MC;
            load_state = 1'b1;
            phase_n    = PHASE_0;
            // compare guards the decrement so round_count never wraps
            if (round_count == RC_ONE) begin
              state_n       = LAST_ROUND;
              round_count_n = '0;
            end else begin
              round_count_n = round_count - RC_ONE;
            end
          end
          default: begin
            state_n       = IDLE;
            phase_n       = PHASE_0;
            round_count_n = RC_INIT;
          end
        endcase
      end

      LAST_ROUND: begin
        busy    = 1'b1;
        mux_sel = 1'b1;
        case (phase)
          PHASE_0: begin
            step       = INV_SR_SB;
            load_state = 1'b1;
            phase_n    = PHASE_1;
          end
          PHASE_1: begin
            step       = ARK;
            req_key    = 1'b1;
            load_state = key_valid;
            // reload so DONE and the following IDLE present key_idx=NUM_ROUNDS
            if (key_valid) begin
              state_n       = DONE;
              phase_n       = PHASE_0;
              round_count_n = RC_INIT;
            end
          end
          default: begin
            state_n       = IDLE;
            phase_n       = PHASE_0;
            round_count_n = RC_INIT;
          end
        endcase
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n       = IDLE;
        phase_n       = PHASE_0;
        round_count_n = RC_INIT;
      end
    endcase
  end

  assign round_step = step;
  assign key_idx    = round_count;

endmodule

// File: tb/tb_decryption_fsm.sv
// Randomized bench for decryption_fsm against a step-queue reference model:
// each operation is the list of datapath steps it must issue, consumed per cycle.
module tb_decryption_fsm;

  localparam int NR = 10;
  localparam int KW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          key_valid = 1'b0;
  logic          busy, done, mux_sel, load_state, req_key;
  logic [1:0]    round_step;
  logic [KW-1:0] key_idx;

  decryption_fsm #(.NUM_ROUNDS(NR), .KEY_IDX_W(KW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .key_valid  (key_valid),
    .busy       (busy),
    .done       (done),
    .mux_sel    (mux_sel),
    .load_state (load_state),
    .round_step (round_step),
    .req_key    (req_key),
    .key_idx    (key_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] step;  // 1 InvSR/SB, 2 ARK, 3 InvMC
    int         idx;
  } step_t;

  step_t m_q[$];
  int    m_mode   = 0;   // 0 idle, 1 operation in progress, 2 done cycle
  bit    m_first  = 1'b0;
  bit    m_known  = 1'b0;
  int    m_stalls = 0;

  int    got_keys[$];
  int    busy_cnt = 0;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build_op();
    m_q.delete();
    m_q.push_back('{2'd2, NR});
    for (int r = NR - 1; r >= 1; r--) begin
      m_q.push_back('{2'd1, r});
      m_q.push_back('{2'd2, r});
      m_q.push_back('{2'd3, r});
    end
    m_q.push_back('{2'd1, 0});
    m_q.push_back('{2'd2, 0});
    m_first  = 1'b1;
    m_stalls = 0;
  endfunction

  // {busy, done, mux_sel, load_state, round_step, req_key, key_idx}
  function automatic logic [31:0] expected(input logic kv);
    logic [31:0] e;
    e = 32'd0;
    case (m_mode)
      1: begin
        e[KW+6]     = 1'b1;
        e[KW+4]     = !m_first;
        e[KW+3]     = (m_q[0].step != 2'd2) || kv;
        e[KW+2:KW+1] = m_q[0].step;
        e[KW]       = (m_q[0].step == 2'd2);
        e[KW-1:0]   = KW'(m_q[0].idx);
      end
      2: begin
        e[KW+5]   = 1'b1;
        e[KW-1:0] = KW'(NR);
      end
      default: e[KW-1:0] = KW'(NR);
    endcase
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic st, input logic kv);
    logic [31:0] got;
    @(negedge clk);
    reset_n   = rst;
    start     = st;
    key_valid = kv;
    #1;
    got = 32'd0;
    got[KW+6:0] = {busy, done, mux_sel, load_state, round_step, req_key, key_idx};
    if (m_known) begin
      chk("outputs", got, expected(kv));
      if (rst) begin
        if (req_key && key_valid) got_keys.push_back(int'(key_idx));
        if (busy) busy_cnt++;
        if (done) begin
          chk("busy_len", busy_cnt, 3 * NR + m_stalls);
          chk("key_count", got_keys.size(), NR + 1);
          for (int i = 0; i < got_keys.size() && i <= NR; i++)
            chk("key_order", got_keys[i], NR - i);
          got_keys.delete();
          busy_cnt = 0;
        end
      end
    end
    if (!rst) begin
      m_mode  = 0;
      m_q.delete();
      m_stalls = 0;
      m_known = 1'b1;
      got_keys.delete();
      busy_cnt = 0;
    end else begin
      case (m_mode)
        0: if (st) begin build_op(); m_mode = 1; end
        1: begin
          if (m_q[0].step == 2'd2 && !kv) m_stalls++;
          else begin
            void'(m_q.pop_front());
            m_first = 1'b0;
            if (m_q.size() == 0) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  initial begin
    int stall_left;
    bit did_rst;
    logic kv;

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);

    // zero-wait key store, single start pulse
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) cyc(1'b1, 1'b0, 1'b1);

    // three-cycle stall at key 5 and a stray start mid-operation
    stall_left = 3;
    for (int i = 0; i < 42; i++) begin
      kv = !(m_mode == 1 && m_q[0].step == 2'd2 && m_q[0].idx == 5 && stall_left > 0);
      if (!kv) stall_left--;
      cyc(1'b1, (i == 0) || (i == 12), kv);
    end

    // start held high: back-to-back operations
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
    while (m_mode != 0) cyc(1'b1, 1'b0, 1'b1);

    // reset during middle round 4, then a fresh operation
    did_rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!did_rst && m_mode == 1 && m_q[0].idx == 4) begin
        did_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
      end else begin
        cyc(1'b1, 1'b0, $urandom_range(0, 1) == 1);
      end
    end
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) cyc(1'b1, 1'b0, 1'b1);

    // random traffic: key stalls, stray starts, occasional reset
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
